// File: rtl/i2c_link.sv
// rtl/i2c_link.sv - single-byte I2C master and addressed I2C slave joined on one open-drain bus
// Ports: clk, rst (sync, active high)
//        master side: addr, tx_data, i2c_en, rw -> is_ack, is_nack, rx_data, ready
//        bus:         sda, scl (open drain, external pull-ups)
//        slave side:  slv_tx_data, slv_tx_valid -> slv_rx_data, slv_rx_valid
module i2c_link #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50,
    parameter int         CLK_DIV    = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] addr,
    input  logic [7:0] tx_data,
    input  logic       i2c_en,
    input  logic       rw,
    output logic       is_ack,
    output logic       is_nack,
    output logic [7:0] rx_data,
    output logic       ready,
    inout  wire        sda,
    inout  wire        scl,
    input  logic [7:0] slv_tx_data,
    input  logic       slv_tx_valid,
    output logic [7:0] slv_rx_data,
    output logic       slv_rx_valid
);
    localparam logic [15:0] QMAX = 16'(CLK_DIV - 1);

    // ---------------- master core ----------------
    typedef enum logic [3:0] {
        M_IDLE, M_START, M_ADDR, M_AACK, M_WDATA, M_WACK, M_RDATA, M_RNACK, M_STOP
    } m_state_t;

    m_state_t    m_st, m_nx;
    logic [15:0] m_qcnt;
    logic [1:0]  m_ph;          // quarter phase inside the current bit
    logic [2:0]  m_bit;
    logic [7:0]  m_sh, m_txd;
    logic        m_rw, m_sbit;
    logic        m_sda_oe, m_scl_oe, m_sda_c, m_scl_c;
    logic [1:0]  m_sda_sync;
    logic        m_tick, m_bit_end;

    assign m_tick    = (m_st != M_IDLE) && (m_qcnt == QMAX);
    assign m_bit_end = m_tick && (m_ph == 2'd3);
    assign ready     = (m_st == M_IDLE);

    always_comb begin
        m_nx    = m_st;
        // bit phases: 0 SCL low, 1 SDA change, 2 SCL high, 3 sample taken at its start
        m_scl_c = ~m_ph[1];
        m_sda_c = m_sda_oe;     // SDA held while SCL falls in phase 0
        case (m_st)
            M_IDLE:  if (i2c_en) m_nx = M_START;
            M_START: if (m_tick && m_ph == 2'd1) m_nx = M_ADDR;
            M_ADDR:  if (m_bit_end && m_bit == 3'd7) m_nx = M_AACK;
            M_AACK:  if (m_bit_end) m_nx = m_sbit ? M_STOP : (m_rw ? M_RDATA : M_WDATA);
            M_WDATA: if (m_bit_end && m_bit == 3'd7) m_nx = M_WACK;
            M_WACK:  if (m_bit_end) m_nx = M_STOP;
            M_RDATA: if (m_bit_end && m_bit == 3'd7) m_nx = M_RNACK;
            M_RNACK: if (m_bit_end) m_nx = M_STOP;
            M_STOP:  if (m_bit_end) m_nx = M_IDLE;
            default: m_nx = M_IDLE;
        endcase
        case (m_st)
            M_IDLE:  begin m_scl_c = 1'b0; m_sda_c = 1'b0; end
            M_START: begin m_scl_c = 1'b0; if (m_ph == 2'd1) m_sda_c = 1'b1; end
            M_ADDR, M_WDATA: if (m_ph != 2'd0) m_sda_c = ~m_sh[7];
            M_STOP:  if (m_ph != 2'd0) m_sda_c = (m_ph != 2'd3);   // release while SCL high = STOP
            default: if (m_ph != 2'd0) m_sda_c = 1'b0;             // ACK slots, read bits, NACK
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_st       <= M_IDLE;
            m_qcnt     <= '0;
            m_ph       <= '0;
            m_bit      <= '0;
            m_sh       <= '0;
            m_txd      <= '0;
            m_rw       <= 1'b0;
            m_sbit     <= 1'b1;
            m_sda_oe   <= 1'b0;
            m_scl_oe   <= 1'b0;
            m_sda_sync <= 2'b11;
            is_ack     <= 1'b0;
            is_nack    <= 1'b0;
            rx_data    <= '0;
        end else begin
            m_st       <= m_nx;
            m_sda_oe   <= m_sda_c;
            m_scl_oe   <= m_scl_c;
            m_sda_sync <= {m_sda_sync[0], sda};
            m_qcnt     <= (m_st == M_IDLE || m_tick) ? 16'd0 : m_qcnt + 16'd1;
            if (m_nx != m_st)
                m_ph <= 2'd0;
            else if (m_tick)
                m_ph <= m_ph + 2'd1;
            if (m_tick && m_ph == 2'd2)
                m_sbit <= m_sda_sync[1];
            if (m_st == M_IDLE)
                m_bit <= 3'd0;
            else if (m_bit_end && (m_st == M_ADDR || m_st == M_WDATA || m_st == M_RDATA))
                m_bit <= m_bit + 3'd1;
            case (m_st)
                M_IDLE: if (i2c_en) begin
                    m_sh    <= {addr, rw};
                    m_txd   <= tx_data;
                    m_rw    <= rw;
                    is_ack  <= 1'b0;
                    is_nack <= 1'b0;
                end
                M_ADDR, M_WDATA: if (m_bit_end) m_sh <= {m_sh[6:0], 1'b0};
                M_AACK: if (m_bit_end) begin
                    if (m_sbit) is_nack <= 1'b1;
                    m_sh <= m_txd;
                end
                M_WACK: if (m_bit_end) begin
                    is_ack  <= ~m_sbit;
                    is_nack <= m_sbit;
                end
                M_RDATA: if (m_bit_end) m_sh <= {m_sh[6:0], m_sbit};
                M_RNACK: if (m_bit_end) begin
                    rx_data <= m_sh;
                    is_ack  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // ---------------- slave core ----------------
    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_AACK, S_WDATA, S_WACK, S_RDATA, S_RACK
    } s_state_t;

    s_state_t   s_st, s_nx;
    logic [2:0] s_sda_sync, s_scl_sync;  // [1] synchronized level, [2] previous level
    logic [7:0] s_sh;
    logic [3:0] s_cnt;
    logic       s_rw, s_sda_oe;
    logic       s_sda, s_rise, s_fall, s_start, s_stop, s_match;

    assign s_sda   = s_sda_sync[1];
    assign s_rise  = s_scl_sync[1] & ~s_scl_sync[2];
    assign s_fall  = ~s_scl_sync[1] & s_scl_sync[2];
    assign s_start = s_scl_sync[1] & s_scl_sync[2] & s_sda_sync[2] & ~s_sda_sync[1];
    assign s_stop  = s_scl_sync[1] & s_scl_sync[2] & ~s_sda_sync[2] & s_sda_sync[1];
    // a read with nothing to send is refused by staying silent on the address ACK
    assign s_match = (s_sh[7:1] == SLAVE_ADDR) && (!s_sh[0] || slv_tx_valid);

    always_comb begin
        s_nx = s_st;
        if (s_start)
            s_nx = S_ADDR;
        else if (s_stop)
            s_nx = S_IDLE;
        else begin
            case (s_st)
                S_ADDR:  if (s_fall && s_cnt == 4'd8) s_nx = s_match ? S_AACK : S_IDLE;
                S_AACK:  if (s_fall) s_nx = s_rw ? S_RDATA : S_WDATA;
                S_WDATA: if (s_fall && s_cnt == 4'd8) s_nx = S_WACK;
                S_WACK:  if (s_fall) s_nx = S_IDLE;
                S_RDATA: if (s_fall && s_cnt == 4'd8) s_nx = S_RACK;
                S_RACK:  if (s_rise) s_nx = s_sda ? S_IDLE : S_AACK;  // master ACK asks for another byte
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_st         <= S_IDLE;
            s_sda_sync   <= 3'b111;
            s_scl_sync   <= 3'b111;
            s_sh         <= '0;
            s_cnt        <= '0;
            s_rw         <= 1'b0;
            s_sda_oe     <= 1'b0;
            slv_rx_data  <= '0;
            slv_rx_valid <= 1'b0;
        end else begin
            s_st         <= s_nx;
            s_sda_sync   <= {s_sda_sync[1:0], sda};
            s_scl_sync   <= {s_scl_sync[1:0], scl};
            slv_rx_valid <= 1'b0;
            if (s_start || s_stop) begin
                s_cnt    <= 4'd0;
                s_sda_oe <= 1'b0;
            end else begin
                case (s_st)
                    S_ADDR, S_WDATA: begin
                        if (s_rise) begin
                            s_sh  <= {s_sh[6:0], s_sda};
                            s_cnt <= s_cnt + 4'd1;
                            if (s_st == S_WDATA && s_cnt == 4'd7) begin
                                slv_rx_data  <= {s_sh[6:0], s_sda};
                                slv_rx_valid <= 1'b1;
                            end
                        end
                        if (s_fall && s_cnt == 4'd8) begin
                            s_sda_oe <= (s_st == S_WDATA) || s_match;
                            s_cnt    <= 4'd0;
                            if (s_st == S_ADDR) s_rw <= s_sh[0];
                        end
                    end
                    S_AACK: if (s_fall) begin
                        s_cnt <= 4'd0;
                        if (s_rw) begin
                            s_sh     <= slv_tx_data;
                            s_sda_oe <= ~slv_tx_data[7];
                        end else begin
                            s_sda_oe <= 1'b0;
                        end
                    end
                    S_WACK: if (s_fall) s_sda_oe <= 1'b0;
                    S_RDATA: begin
                        if (s_rise) s_cnt <= s_cnt + 4'd1;
                        if (s_fall) begin
                            s_sh     <= {s_sh[6:0], 1'b0};
                            s_sda_oe <= (s_cnt == 4'd8) ? 1'b0 : ~s_sh[6];
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // open drain: only ever pull low or release
    assign sda = (m_sda_oe || s_sda_oe) ? 1'b0 : 1'bz;
    assign scl = m_scl_oe ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_link.sv
// tb/tb_i2c_link.sv - directed self-checking bench for i2c_link
module tb_i2c_link;
    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] addr;
    logic [7:0] tx_data, rx_data, slv_tx_data, slv_rx_data;
    logic       i2c_en, rw, is_ack, is_nack, ready, slv_tx_valid, slv_rx_valid;
    wire        sda, scl;

    pullup (sda);
    pullup (scl);

    int          n_vec = 0;
    int          n_err = 0;
    int          rise_cnt = 0;
    int          pulse_cnt = 0;
    int          rise_base, pulse_base;
    logic [31:0] sda_bits = '0;   // SDA at each SCL rise, newest in bit 0

    i2c_link #(.SLAVE_ADDR(7'h50), .CLK_DIV(8)) dut (
        .clk(clk), .rst(rst), .addr(addr), .tx_data(tx_data), .i2c_en(i2c_en), .rw(rw),
        .is_ack(is_ack), .is_nack(is_nack), .rx_data(rx_data), .ready(ready),
        .sda(sda), .scl(scl),
        .slv_tx_data(slv_tx_data), .slv_tx_valid(slv_tx_valid),
        .slv_rx_data(slv_rx_data), .slv_rx_valid(slv_rx_valid)
    );

    always #5 clk = ~clk;

    always @(posedge scl) begin
        rise_cnt <= rise_cnt + 1;
        sda_bits <= {sda_bits[30:0], sda};
    end

    always @(negedge clk) begin
        if (slv_rx_valid === 1'b1) pulse_cnt <= pulse_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input logic [6:0] a, input logic r, input logic [7:0] d);
        int t;
        addr = a; rw = r; tx_data = d; i2c_en = 1'b1;
        rise_base = rise_cnt; pulse_base = pulse_cnt;
        @(negedge clk);
        i2c_en = 1'b0;
        check("ready_drop", ready, 1'b0);
        t = 0;
        while (ready !== 1'b1 && t < 5000) begin @(negedge clk); t++; end
        check("xfer_done", t < 5000, 1'b1);
    endtask

    initial begin
        int t;
        logic [7:0] d;
        rst = 1'b1; addr = '0; tx_data = '0; i2c_en = 1'b0; rw = 1'b0;
        slv_tx_data = '0; slv_tx_valid = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("rst_ready", ready, 1'b1);
        check("rst_ack", is_ack, 1'b0);
        check("rst_nack", is_nack, 1'b0);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_slv_rx", slv_rx_data, 8'h00);
        check("rst_slv_valid", slv_rx_valid, 1'b0);
        check("rst_sda", sda, 1'b1);
        check("rst_scl", scl, 1'b1);

        // writes 01..0A
        for (int i = 1; i <= 10; i++) begin
            d = 8'(i);
            xfer(7'h50, 1'b0, d);
            check("wr_slv_rx", slv_rx_data, d);
            check("wr_pulses", pulse_cnt - pulse_base, 1);
            check("wr_ack", {is_ack, is_nack}, 2'b10);
            check("wr_bus_byte", sda_bits[9:2], d);
            check("wr_bus_addr", sda_bits[18:11], 8'hA0);
            check("wr_rises", rise_cnt - rise_base, 19);
        end

        // reads 00,11,..,99
        for (int i = 0; i < 10; i++) begin
            d = 8'(i * 17);
            slv_tx_data = d;
            xfer(7'h50, 1'b1, 8'h00);
            check("rd_rx_data", rx_data, d);
            check("rd_ack", {is_ack, is_nack}, 2'b10);
            check("rd_master_nack", sda_bits[1], 1'b1);
            check("rd_slave_ack", sda_bits[10], 1'b0);
            check("rd_bus_addr", sda_bits[18:11], 8'hA1);
            check("rd_pulses", pulse_cnt - pulse_base, 0);
        end

        // wrong address
        xfer(7'h51, 1'b0, 8'h77);
        check("wa_ack", {is_ack, is_nack}, 2'b01);
        check("wa_pulses", pulse_cnt - pulse_base, 0);
        check("wa_rises", rise_cnt - rise_base, 10);
        check("wa_nack_bit", sda_bits[1], 1'b1);
        check("wa_stop_low", sda_bits[0], 1'b0);
        check("wa_bus_idle", {sda, scl, ready}, 3'b111);
        check("wa_slv_rx", slv_rx_data, 8'h0A);

        // read with nothing to send
        slv_tx_valid = 1'b0;
        slv_tx_data = 8'hEE;
        xfer(7'h50, 1'b1, 8'h00);
        check("nv_ack", {is_ack, is_nack}, 2'b01);
        check("nv_rx_data", rx_data, 8'h99);
        check("nv_rises", rise_cnt - rise_base, 10);
        slv_tx_valid = 1'b1;

        // reset during the data phase
        addr = 7'h50; rw = 1'b0; tx_data = 8'h5A; i2c_en = 1'b1;
        rise_base = rise_cnt;
        @(negedge clk);
        i2c_en = 1'b0;
        t = 0;
        while (rise_cnt - rise_base < 12 && t < 5000) begin @(negedge clk); t++; end
        check("mid_wait", t < 5000, 1'b1);
        check("mid_sda_low", sda, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_sda", sda, 1'b1);
        check("mid_rst_scl", scl, 1'b1);
        check("mid_rst_ready", ready, 1'b1);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        xfer(7'h50, 1'b0, 8'h3C);
        check("post_slv_rx", slv_rx_data, 8'h3C);
        check("post_pulses", pulse_cnt - pulse_base, 1);
        check("post_ack", {is_ack, is_nack}, 2'b10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
